// File: rtl/fir_decim_fifo.sv
// ---------------------------------------------------------------------------
// fir_decim_fifo
//   Downstream stage of the FIR filter. Keeps one of every DECIM in_en
//   samples, scales the kept sample by an arithmetic right shift, saturates
//   it to OUT_W bits and buffers it in a DEPTH-entry FIFO read out over a
//   valid/ready interface.
//
// Handshake: a sample is transferred on every rising edge where
//   out_valid=1 and out_ready=1. out_valid never depends on out_ready, and
//   out_data/out_valid hold steady while out_valid=1 and out_ready=0.
//   out_ready while out_valid=0 has no effect.
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   in_data    filter output sample (signed, IN_W)
//   in_en      in_data is a new sample this cycle
//   out_data   FIFO head sample (signed, OUT_W); holds last value when empty
//   out_valid  out_data holds a valid sample
//   out_ready  sink accepts out_data this cycle
//   level      FIFO occupancy, 0..DEPTH
//   overflow   sticky: a kept sample was dropped because the FIFO was full
//   clr_ovf    synchronous clear of overflow (a same-cycle drop wins)
// ---------------------------------------------------------------------------
module fir_decim_fifo #(
  parameter int IN_W  = 32,
  parameter int OUT_W = 10,
  parameter int DECIM = 4,
  parameter int SHIFT = 0,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [IN_W-1:0]          in_data,
  input  logic                     in_en,
  output logic [OUT_W-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  input  logic                     clr_ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam int PW = (DECIM > 1) ? $clog2(DECIM) : 1;

  localparam logic [PW-1:0] PHASE_LAST = PW'(DECIM - 1);
  localparam logic [LW-1:0] LEVEL_FULL = LW'(DEPTH);

  // Saturation bounds expressed at input width: +2^(OUT_W-1)-1 and -2^(OUT_W-1).
  localparam logic signed [IN_W-1:0] SAT_HI = {{(IN_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [IN_W-1:0] SAT_LO = {{(IN_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic [PW-1:0]    phase_q,    phase_d;
  logic [AW-1:0]    wr_ptr_q,   wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q,   rd_ptr_d;
  logic [LW-1:0]    level_q,    level_d;
  logic             overflow_q, overflow_d;
  logic [OUT_W-1:0] out_data_q, out_data_d;
  logic [OUT_W-1:0] mem_q [DEPTH];

  logic signed [IN_W-1:0] scaled;
  logic [OUT_W-1:0]       sat_data;
  logic                   keep;
  logic                   pop;
  logic                   push;
  logic                   drop;

  // Shift then clamp to the OUT_W signed range.
  always_comb begin
    scaled = $signed(in_data) >>> SHIFT;
    if (scaled > SAT_HI) begin
      sat_data = SAT_HI[OUT_W-1:0];
    end else if (scaled < SAT_LO) begin
      sat_data = SAT_LO[OUT_W-1:0];
    end else begin
      sat_data = scaled[OUT_W-1:0];
    end
  end

  always_comb begin
    keep = in_en && (phase_q == '0);
    pop  = (level_q != '0) && out_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    push = keep && ((level_q != LEVEL_FULL) || pop);
    drop = keep && !push;

    phase_d = phase_q;
    if (in_en) begin
      phase_d = (phase_q == PHASE_LAST) ? '0 : phase_q + PW'(1);
    end

    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

    level_d = level_q;
    if (push && !pop) begin
      level_d = level_q + LW'(1);
    end else if (pop && !push) begin
      level_d = level_q - LW'(1);
    end

    overflow_d = overflow_q;
    if (drop) begin
      overflow_d = 1'b1;
    end else if (clr_ovf) begin
      overflow_d = 1'b0;
    end

    // out_data is a register tracking the next head entry. When the new head
    // slot is the one being written this edge, take the incoming sample
    // instead of the stale memory contents. When the FIFO goes empty the
    // register keeps the last value presented.
    out_data_d = out_data_q;
    if (level_d != '0) begin
      if (push && (wr_ptr_q == rd_ptr_d)) begin
        out_data_d = sat_data;
      end else begin
        out_data_d = mem_q[rd_ptr_d];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      phase_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      overflow_q <= 1'b0;
      out_data_q <= '0;
    end else begin
      phase_q    <= phase_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      out_data_q <= out_data_d;
    end
  end

  // Storage needs no reset: occupancy is tracked entirely by level/pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_ptr_q] <= sat_data;
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = (level_q != '0);
  assign level     = level_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_fir_decim_fifo.sv
// ---------------------------------------------------------------------------
// tb_fir_decim_fifo
//   Three instances share clk/reset:
//     dut0: DECIM=4, SHIFT=0   (decimation, reset mid-stream)
//     dut1: DECIM=1, SHIFT=0   (saturation, backpressure, overflow, full push/pop)
//     dut2: DECIM=1, SHIFT=2   (shift + saturation)
//   Drivers push hand-computed expected samples into per-instance queues; a
//   negedge monitor pops and compares whenever out_valid & out_ready.
// ---------------------------------------------------------------------------
module tb_fir_decim_fifo;

  localparam int IN_W  = 32;
  localparam int OUT_W = 10;
  localparam int LW    = 4;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic [IN_W-1:0]  in_data   [3];
  logic             in_en     [3];
  logic [OUT_W-1:0] out_data  [3];
  logic             out_valid [3];
  logic             out_ready [3];
  logic [LW-1:0]    level     [3];
  logic             overflow  [3];
  logic             clr_ovf   [3];

  fir_decim_fifo #(.IN_W(IN_W), .OUT_W(OUT_W), .DECIM(4), .SHIFT(0), .DEPTH(8)) u_d4 (
    .clk(clk), .reset(reset), .in_data(in_data[0]), .in_en(in_en[0]),
    .out_data(out_data[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .level(level[0]), .overflow(overflow[0]), .clr_ovf(clr_ovf[0])
  );

  fir_decim_fifo #(.IN_W(IN_W), .OUT_W(OUT_W), .DECIM(1), .SHIFT(0), .DEPTH(8)) u_d1 (
    .clk(clk), .reset(reset), .in_data(in_data[1]), .in_en(in_en[1]),
    .out_data(out_data[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .level(level[1]), .overflow(overflow[1]), .clr_ovf(clr_ovf[1])
  );

  fir_decim_fifo #(.IN_W(IN_W), .OUT_W(OUT_W), .DECIM(1), .SHIFT(2), .DEPTH(8)) u_s2 (
    .clk(clk), .reset(reset), .in_data(in_data[2]), .in_en(in_en[2]),
    .out_data(out_data[2]), .out_valid(out_valid[2]), .out_ready(out_ready[2]),
    .level(level[2]), .overflow(overflow[2]), .clr_ovf(clr_ovf[2])
  );

  // ---------------- scoreboard ----------------
  logic [OUT_W-1:0] exp_q0[$];
  logic [OUT_W-1:0] exp_q1[$];
  logic [OUT_W-1:0] exp_q2[$];
  int               cyc_q0[$];
  int               n_tests = 0;
  int               n_fail  = 0;
  bit               chk_lat = 1'b0;

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int qsize(input int k);
    case (k)
      0:       return exp_q0.size();
      1:       return exp_q1.size();
      default: return exp_q2.size();
    endcase
  endfunction

  task automatic push_exp(input int k, input int v);
    logic [31:0] w;
    w = v;
    case (k)
      0: begin exp_q0.push_back(w[OUT_W-1:0]); cyc_q0.push_back(cyc + 1); end
      1: exp_q1.push_back(w[OUT_W-1:0]);
      default: exp_q2.push_back(w[OUT_W-1:0]);
    endcase
  endtask

  task automatic mon_pop(input int k);
    logic [OUT_W-1:0] e;
    int               ec;
    bit               have;
    have = 1'b0;
    e    = '0;
    ec   = 0;
    case (k)
      0: if (exp_q0.size() > 0) begin e = exp_q0.pop_front(); ec = cyc_q0.pop_front(); have = 1'b1; end
      1: if (exp_q1.size() > 0) begin e = exp_q1.pop_front(); have = 1'b1; end
      default: if (exp_q2.size() > 0) begin e = exp_q2.pop_front(); have = 1'b1; end
    endcase
    if (!have) begin
      n_tests++;
      n_fail++;
      $display("FAIL unexpected_out dut%0d: got %0d, expected no output", k, $signed(out_data[k]));
    end else begin
      check($sformatf("out_data dut%0d", k), $signed(out_data[k]), $signed(e));
      if (k == 0 && chk_lat) check("d4_latency_cycle", cyc, ec);
    end
  endtask

  // Monitor: compares every transfer, decoupled from the drivers.
  always @(negedge clk) begin
    if (!reset) begin
      for (int k = 0; k < 3; k++) begin
        if (out_valid[k] && out_ready[k]) mon_pop(k);
      end
      if (chk_lat) check("d4_level_le1", (level[0] <= 4'd1), 1);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Present one in_en sample for one edge; kept samples go to the scoreboard.
  task automatic send(input int k, input int v, input bit kept, input int expv);
    in_data[k] = v;
    in_en[k]   = 1'b1;
    if (kept) push_exp(k, expv);
    tick();
    in_en[k]   = 1'b0;
  endtask

  task automatic drain(input int k, input string name);
    int n;
    n = 0;
    out_ready[k] = 1'b1;
    while (qsize(k) > 0 && n < 100) begin
      tick();
      n++;
    end
    check({name, "_drained"}, qsize(k), 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    for (int k = 0; k < 3; k++) begin
      in_data[k] = '0; in_en[k] = 1'b0; out_ready[k] = 1'b0; clr_ovf[k] = 1'b0;
    end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_valid dut%0d", k),    out_valid[k], 0);
      check($sformatf("rst_level dut%0d", k),    level[k], 0);
      check($sformatf("rst_data dut%0d", k),     $signed(out_data[k]), 0);
      check($sformatf("rst_overflow dut%0d", k), overflow[k], 0);
    end
    reset = 1'b0;
    tick();

    // Basic decimation: 0..15 continuous, keep 0,4,8,12
    out_ready[0] = 1'b1;
    chk_lat      = 1'b1;
    for (int i = 0; i < 16; i++) send(0, i, (i % 4) == 0, i);
    drain(0, "decim");
    tick();
    chk_lat = 1'b0;

    // Saturation, SHIFT=0
    out_ready[1] = 1'b1;
    send(1,  600, 1,  511);
    send(1, -600, 1, -512);
    send(1,  511, 1,  511);
    send(1, -512, 1, -512);
    send(1,  512, 1,  511);
    send(1, -513, 1, -512);
    send(1, 32'sh7fffffff, 1, 511);
    drain(1, "sat");

    // Shift + saturation, SHIFT=2
    out_ready[2] = 1'b1;
    send(2,  2000, 1,  500);
    send(2,    -7, 1,   -2);
    send(2,  2047, 1,  511);
    send(2,  2048, 1,  511);
    send(2, -2048, 1, -512);
    send(2, -2052, 1, -512);
    send(2,     3, 1,    0);
    send(2,    -1, 1,   -1);
    drain(2, "shift");

    // Backpressure and stability
    out_ready[1] = 1'b0;
    for (int i = 10; i <= 14; i++) send(1, i, 1, i);
    check("bp_level", level[1], 5);
    for (int i = 0; i < 3; i++) begin
      check("bp_hold_valid", out_valid[1], 1);
      check("bp_hold_data", $signed(out_data[1]), 10);
      tick();
    end
    drain(1, "bp");
    check("bp_valid_drop", out_valid[1], 0);
    check("bp_level_zero", level[1], 0);
    check("bp_data_retained", $signed(out_data[1]), 14);

    // Overflow: 9 pushes into 8 entries, sample 9 lost
    out_ready[1] = 1'b0;
    for (int i = 1; i <= 8; i++) send(1, i, 1, i);
    send(1, 9, 0, 0);
    check("ovf_level", level[1], 8);
    check("ovf_flag", overflow[1], 1);
    check("ovf_head", $signed(out_data[1]), 1);
    drain(1, "ovf");
    check("ovf_sticky", overflow[1], 1);
    clr_ovf[1] = 1'b1;
    tick();
    clr_ovf[1] = 1'b0;
    check("ovf_cleared", overflow[1], 0);

    // Full with simultaneous push/pop, then drop coincident with clr_ovf
    out_ready[1] = 1'b0;
    for (int i = 1; i <= 8; i++) send(1, i, 1, i);
    check("full_level", level[1], 8);
    check("full_no_ovf", overflow[1], 0);
    out_ready[1] = 1'b1;
    send(1, 99, 1, 99);
    out_ready[1] = 1'b0;
    check("pp_level", level[1], 8);
    check("pp_no_ovf", overflow[1], 0);
    check("pp_head", $signed(out_data[1]), 2);
    clr_ovf[1] = 1'b1;
    send(1, 100, 0, 0);
    clr_ovf[1] = 1'b0;
    check("clr_vs_drop", overflow[1], 1);
    check("clr_vs_drop_level", level[1], 8);
    drain(1, "pp");

    // Reset mid-stream: level=3, phase=2 on dut0
    out_ready[0] = 1'b0;
    for (int i = 0; i < 10; i++) send(0, 20 + i, (i % 4) == 0, 20 + i);
    check("pre_rst_level", level[0], 3);
    #2;
    reset = 1'b1;
    #1;
    check("midrst_valid", out_valid[0], 0);
    check("midrst_level", level[0], 0);
    check("midrst_data", $signed(out_data[0]), 0);
    check("midrst_overflow", overflow[1], 0);
    exp_q0.delete();
    cyc_q0.delete();
    #2;
    reset = 1'b0;
    tick();
    out_ready[0] = 1'b1;
    send(0, 77, 1, 77);
    send(0, 78, 0, 0);
    drain(0, "post_rst");
    tick();
    check("post_rst_level", level[0], 0);
    check("post_rst_valid", out_valid[0], 0);

    repeat (3) tick();
    for (int k = 0; k < 3; k++) check($sformatf("final_queue dut%0d", k), qsize(k), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/fir_decim_fifo.md
Name: fir_decim_fifo

Overview:
- Downstream stage of the N-tap FIR filter; consumes the filter's 32-bit signed output stream.
- Keeps one of every DECIM input samples (decimation).
- Scales each kept sample by an arithmetic right shift, then saturates it to OUT_W bits.
- Buffers results in a DEPTH-entry FIFO and presents them on a valid/ready interface to the sample sink.

Parameters:
- IN_W, 32: width of the filter output sample; signed two's complement.
- OUT_W, 10: width of the decimated output sample; signed two's complement.
- DECIM, 4: decimation factor; keep 1 of every DECIM in_en samples; legal range >= 1.
- SHIFT, 0: arithmetic right shift applied before saturation; legal range 0..IN_W-1.
- DEPTH, 8: FIFO depth in entries; power of two, >= 2.

Ports:
- clk  input  1  rising-edge clock; single clock domain.
- reset  input  1  asynchronous, active-high reset.
- in_data  input  IN_W  filter output sample, signed.
- in_en  input  1  in_data is a new sample this cycle.
- out_data  output  OUT_W  FIFO head sample, signed.
- out_valid  output  1  out_data holds a valid sample.
- out_ready  input  1  sink accepts out_data this cycle.
- level  output  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH.
- overflow  output  1  sticky flag: a kept sample was dropped.
- clr_ovf  input  1  synchronous clear of overflow.

Behaviour:
- Reset (async assert, sync use on release):
  - phase=0, FIFO empty, level=0.
  - out_valid=0, out_data=0, overflow=0.
  - Asserting reset mid-operation discards all buffered samples immediately.
- Phase counter:
  - Counts 0..DECIM-1 and advances only on in_en; wraps from DECIM-1 to 0.
  - A sample is kept when in_en=1 and phase==0, so the first in_en after reset is kept.
  - DECIM=1 keeps every sample.
  - in_en=0 leaves phase and the FIFO untouched.
- Scaling:
  - s = in_data >>> SHIFT (sign-extended).
  - Saturate s to the range [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - Default range is -512..511.
- Push and pop:
  - push = kept sample.
  - pop = out_valid & out_ready.
  - Push is accepted when level<DEPTH, or when level==DEPTH and pop is asserted the same cycle.
  - Push at level==DEPTH without pop: sample dropped, overflow set at the next edge, FIFO unchanged.
- Simultaneous push and pop:
  - Both occur; level unchanged; order preserved.
  - At empty, no bypass: pop cannot happen because out_valid=0.
- Output side:
  - out_valid = (level!=0); out_data = head entry.
  - Both are registered/driven from FIFO state; no combinational path from in_data or in_en to outputs.
  - A sample pushed into an empty FIFO at edge t appears with out_valid=1 after edge t (1-cycle latency).
  - While out_valid=1 and out_ready=0, out_data and out_valid hold stable.
  - out_ready while out_valid=0 is ignored.
  - When out_valid=0, out_data retains its last value, or 0 after reset.
- level: updates at each edge as +1 (push only), -1 (pop only), or 0 (both or neither).
- overflow:
  - Sticky once set.
  - clr_ovf=1 clears it at the next edge.
  - If clr_ovf and a drop happen in the same cycle, the set wins and overflow=1.
- Pointers: read and write pointers wrap modulo DEPTH; a full/empty distinction is kept via level.

Test Plan:
- Basic decimation:
  - Stimulus: DECIM=4, SHIFT=0, out_ready=1; in_en=1 continuously; in_data = 0,1,2,...,15.
  - Required: output stream 0,4,8,12; each appears 1 cycle after its input edge; level never exceeds 1.
- Saturation and shift:
  - Stimulus: DECIM=1.
  - SHIFT=0, inputs 600, -600, 511, -512 -> outputs 511, -512, 511, -512.
  - SHIFT=2, input 2000 -> 500; input -7 -> -2.
- Backpressure and stability:
  - Stimulus: DECIM=1, out_ready=0, push 5 samples (10..14).
  - Required: level=5; out_data=10 held steady.
  - Then out_ready=1: outputs 10..14 in order, level returns to 0, out_valid drops after the last one.
- Overflow:
  - Stimulus: DECIM=1, out_ready=0, push 9 samples (1..9).
  - Required: level=8, overflow=1, sample 9 lost; drain yields 1..8.
  - clr_ovf pulse clears overflow.
  - clr_ovf coincident with another drop leaves overflow=1.
- Full with simultaneous push/pop:
  - Stimulus: FIFO full (1..8); next cycle out_ready=1 and a kept sample 99 arrives.
  - Required: 1 popped, 99 accepted, level stays 8, overflow stays 0; drain yields 2..8, 99.
- Reset mid-stream:
  - Stimulus: level=3, phase=2; assert reset between clock edges.
  - Required: out_valid=0, level=0, out_data=0 immediately.
  - After release, the first in_en sample is kept (phase restarted at 0).
